// File: rtl/cpld_uart_ctrl_if.sv
// MMU-side request/completion bundle for the CPLD UART sequencer.
// The MMU drives requests through 'master'; the sequencer answers through 'slave'.
interface cpld_uart_ctrl_if;
  logic       req_read;
  logic       req_write;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  modport master (
    output req_read, req_write, wdata,
    input  busy, done, rdata, err
  );

  modport slave (
    input  req_read, req_write, wdata,
    output busy, done, rdata, err
  );
endinterface

// File: rtl/cpld_uart_ctrl.sv
// Sequencer that turns one-cycle MMU byte requests into timed uart_rdn/uart_wrn strobes
// on the shared base_ram_data[7:0] bus, with synchronized status polling and a single done pulse.
module cpld_uart_ctrl #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned TX_TIMEOUT   = 65535
) (
  input  logic            clk,
  input  logic            rst,
  cpld_uart_ctrl_if.slave mmu,
  output logic            rx_avail,
  output logic            tx_ready,
  output logic            bus_own,
  output logic [7:0]      data_out,
  output logic            data_oe,
  input  logic [7:0]      data_in,
  output logic            uart_rdn,
  output logic            uart_wrn,
  input  logic            uart_dataready,
  input  logic            uart_tbre,
  input  logic            uart_tsre
);

  typedef enum logic [2:0] {
    IDLE, RD_LOW, RECOVER, WR_SETUP, WR_LOW, WR_HOLD, WAIT_TBRE, WAIT_TSRE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [16:0] wcnt_inc;
  logic        rdn_q, rdn_d, wrn_q, wrn_d;
  logic        oe_q, oe_d, own_q, own_d;
  logic [7:0]  dout_q, dout_d, rdata_q, rdata_d;
  logic        done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic        dr_s1_q, dr_s2_q, tbre_s1_q, tbre_s2_q, tsre_s1_q, tsre_s2_q;

  assign wcnt_inc = {1'b0, wcnt_q} + 17'd1;

  // Every registered output is loaded at the edge that leaves the current state,
  // so each state's branch describes what the pins show in the following cycle.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    oe_d    = 1'b0;
    own_d   = 1'b0;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    busy_d  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!busy_q && mmu.req_write) begin
          dout_d  = mmu.wdata;
          oe_d    = 1'b1;
          own_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = WR_SETUP;
        end else if (!busy_q && mmu.req_read) begin
          busy_d = 1'b1;
          if (dr_s2_q) begin
            rdn_d   = 1'b0;
            own_d   = 1'b1;
            pcnt_d  = 4'd1;
            state_d = RD_LOW;
          end else begin
            done_d  = 1'b1;
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = RECOVER;
          end
        end
      end
      RD_LOW: begin
        if (pcnt_q == 4'(PULSE_CYCLES)) begin
          rdata_d = data_in;
          done_d  = 1'b1;
          err_d   = 1'b0;
          pcnt_d  = '0;
          state_d = RECOVER;
        end else begin
          rdn_d  = 1'b0;
          own_d  = 1'b1;
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      WR_SETUP: begin
        oe_d    = 1'b1;
        own_d   = 1'b1;
        wrn_d   = 1'b0;
        pcnt_d  = 4'd1;
        state_d = WR_LOW;
      end
      WR_LOW: begin
        oe_d  = 1'b1;
        own_d = 1'b1;
        if (pcnt_q == 4'(PULSE_CYCLES)) begin
          pcnt_d  = '0;
          state_d = WR_HOLD;
        end else begin
          wrn_d  = 1'b0;
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      WR_HOLD: begin
        wcnt_d  = '0;
        state_d = WAIT_TBRE;
      end
      WAIT_TBRE, WAIT_TSRE: begin
        if ((state_q == WAIT_TBRE) ? tbre_s2_q : tsre_s2_q) begin
          wcnt_d = '0;
          if (state_q == WAIT_TBRE) begin
            state_d = WAIT_TSRE;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = RECOVER;
          end
        end else if (wcnt_inc == 17'(TX_TIMEOUT)) begin
          wcnt_d  = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RECOVER;
        end else begin
          wcnt_d = wcnt_inc[15:0];
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      wcnt_q    <= '0;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      oe_q      <= 1'b0;
      own_q     <= 1'b0;
      dout_q    <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      dr_s1_q   <= 1'b0;
      dr_s2_q   <= 1'b0;
      tbre_s1_q <= 1'b0;
      tbre_s2_q <= 1'b0;
      tsre_s1_q <= 1'b0;
      tsre_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      wcnt_q    <= wcnt_d;
      rdn_q     <= rdn_d;
      wrn_q     <= wrn_d;
      oe_q      <= oe_d;
      own_q     <= own_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      dr_s1_q   <= uart_dataready;
      dr_s2_q   <= dr_s1_q;
      tbre_s1_q <= uart_tbre;
      tbre_s2_q <= tbre_s1_q;
      tsre_s1_q <= uart_tsre;
      tsre_s2_q <= tsre_s1_q;
    end
  end

  assign mmu.busy  = busy_q;
  assign mmu.done  = done_q;
  assign mmu.rdata = rdata_q;
  assign mmu.err   = err_q;
  assign rx_avail  = dr_s2_q;
  assign tx_ready  = tbre_s2_q & tsre_s2_q;
  assign bus_own   = own_q;
  assign data_out  = dout_q;
  assign data_oe   = oe_q;
  assign uart_rdn  = rdn_q;
  assign uart_wrn  = wrn_q;

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// Directed bench for cpld_uart_ctrl: reads with/without pending data, writes, timeout,
// request collisions and reset during a write strobe.
module tb_cpld_uart_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_avail, tx_ready, bus_own, data_oe, uart_rdn, uart_wrn;
  logic [7:0] data_out, data_in;
  logic       uart_dataready, uart_tbre, uart_tsre;
  int         total = 0;
  int         bad = 0;

  cpld_uart_ctrl_if mmu ();

  cpld_uart_ctrl #(.PULSE_CYCLES(2), .TX_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mmu(mmu),
    .rx_avail(rx_avail), .tx_ready(tx_ready), .bus_own(bus_own),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mmu.req_read = 1'b0; mmu.req_write = 1'b0; mmu.wdata = 8'h00;
    data_in = 8'h00; uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    total++; if (uart_rdn !== 1'b1) begin bad++; $display("FAIL rst_rdn: got %b want 1", uart_rdn); end
    total++; if (uart_wrn !== 1'b1) begin bad++; $display("FAIL rst_wrn: got %b want 1", uart_wrn); end
    total++; if ({data_oe, bus_own, mmu.busy, mmu.done, mmu.err} !== 5'b0)
      begin bad++; $display("FAIL rst_flags: got oe,own,busy,done,err=%b want 00000", {data_oe, bus_own, mmu.busy, mmu.done, mmu.err}); end
    total++; if ({data_out, mmu.rdata} !== 16'h0000)
      begin bad++; $display("FAIL rst_data: got data_out=%h rdata=%h want 00 00", data_out, mmu.rdata); end
    total++; if ({rx_avail, tx_ready} !== 2'b00)
      begin bad++; $display("FAIL rst_sync: got rx_avail,tx_ready=%b want 00", {rx_avail, tx_ready}); end
  endtask

  task automatic test_read_no_data;
    data_in = 8'h3C;
    tick();
    mmu.req_read = 1'b1;
    tick();
    mmu.req_read = 1'b0;
    total++; if (mmu.done !== 1'b1) begin bad++; $display("FAIL nd_done: got %b want 1", mmu.done); end
    total++; if (mmu.rdata !== 8'h00) begin bad++; $display("FAIL nd_rdata: got %h want 00", mmu.rdata); end
    total++; if ({mmu.err, mmu.busy, uart_rdn, bus_own} !== 4'b0110)
      begin bad++; $display("FAIL nd_flags: got err,busy,rdn,own=%b want 0110", {mmu.err, mmu.busy, uart_rdn, bus_own}); end
    tick();
    total++; if ({mmu.done, mmu.busy, uart_rdn} !== 3'b011)
      begin bad++; $display("FAIL nd_recover: got done,busy,rdn=%b want 011", {mmu.done, mmu.busy, uart_rdn}); end
    tick();
    total++; if (mmu.busy !== 1'b0) begin bad++; $display("FAIL nd_busy_end: got %b want 0", mmu.busy); end
  endtask

  task automatic test_read_pending;
    data_in = 8'hA5;
    uart_dataready = 1'b1;
    tick(); tick();
    total++; if (rx_avail !== 1'b1) begin bad++; $display("FAIL rd_rx_avail: got %b want 1", rx_avail); end
    mmu.req_read = 1'b1;
    tick();
    mmu.req_read = 1'b0;
    total++; if ({uart_rdn, bus_own, mmu.busy, mmu.done, data_oe} !== 5'b01100)
      begin bad++; $display("FAIL rd_e0: got rdn,own,busy,done,oe=%b want 01100", {uart_rdn, bus_own, mmu.busy, mmu.done, data_oe}); end
    tick();
    total++; if ({uart_rdn, mmu.done} !== 2'b00)
      begin bad++; $display("FAIL rd_e1: got rdn,done=%b want 00", {uart_rdn, mmu.done}); end
    tick();
    total++; if ({uart_rdn, mmu.done, mmu.err} !== 3'b110)
      begin bad++; $display("FAIL rd_e2: got rdn,done,err=%b want 110", {uart_rdn, mmu.done, mmu.err}); end
    total++; if (mmu.rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata: got %h want a5", mmu.rdata); end
    tick();
    total++; if ({mmu.done, mmu.busy} !== 2'b01)
      begin bad++; $display("FAIL rd_e3: got done,busy=%b want 01", {mmu.done, mmu.busy}); end
    tick();
    total++; if (mmu.busy !== 1'b0) begin bad++; $display("FAIL rd_e4_busy: got %b want 0", mmu.busy); end
    uart_dataready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write;
    int k;
    int own_bad;
    own_bad = 0;
    mmu.wdata = 8'h5A;
    mmu.req_write = 1'b1;
    tick();
    mmu.req_write = 1'b0;
    mmu.wdata = 8'h00;
    total++; if ({data_oe, uart_wrn, bus_own, mmu.busy} !== 4'b1111)
      begin bad++; $display("FAIL wr_e0: got oe,wrn,own,busy=%b want 1111", {data_oe, uart_wrn, bus_own, mmu.busy}); end
    total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL wr_dout_e0: got %h want 5a", data_out); end
    tick();
    total++; if ({data_oe, uart_wrn} !== 2'b10)
      begin bad++; $display("FAIL wr_e1: got oe,wrn=%b want 10", {data_oe, uart_wrn}); end
    tick();
    total++; if ({data_oe, uart_wrn} !== 2'b10)
      begin bad++; $display("FAIL wr_e2: got oe,wrn=%b want 10", {data_oe, uart_wrn}); end
    tick();
    total++; if ({data_oe, uart_wrn, data_out} !== {2'b11, 8'h5A})
      begin bad++; $display("FAIL wr_hold: got oe,wrn=%b dout=%h want 11 5a", {data_oe, uart_wrn}, data_out); end
    tick();
    total++; if ({data_oe, bus_own, mmu.done, mmu.busy} !== 4'b0001)
      begin bad++; $display("FAIL wr_release: got oe,own,done,busy=%b want 0001", {data_oe, bus_own, mmu.done, mmu.busy}); end
    tick(); tick();
    uart_tbre = 1'b1;
    uart_tsre = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_own !== 1'b0) own_bad++;
      if (mmu.done === 1'b1) begin k = i; break; end
    end
    total++; if (k != 4) begin bad++; $display("FAIL wr_done_latency: got %0d cycles want 4", k); end
    total++; if ({mmu.err, tx_ready, own_bad[0]} !== 3'b010)
      begin bad++; $display("FAIL wr_done_flags: got err=%b tx_ready=%b own_bad=%0d want 0 1 0", mmu.err, tx_ready, own_bad); end
    tick();
    total++; if (mmu.done !== 1'b0) begin bad++; $display("FAIL wr_done_width: got %b want 0", mmu.done); end
    tick();
    total++; if (mmu.busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", mmu.busy); end
    uart_tbre = 1'b0;
    uart_tsre = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout;
    int k;
    int own_bad;
    own_bad = 0;
    mmu.wdata = 8'hC3;
    mmu.req_write = 1'b1;
    tick();
    mmu.req_write = 1'b0;
    tick(); tick(); tick(); tick();
    total++; if ({data_oe, bus_own} !== 2'b00)
      begin bad++; $display("FAIL to_enter: got oe,own=%b want 00", {data_oe, bus_own}); end
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_own !== 1'b0) own_bad++;
      if (mmu.done === 1'b1) begin k = i; break; end
    end
    total++; if (k != 8) begin bad++; $display("FAIL to_latency: got %0d cycles want 8", k); end
    total++; if (mmu.err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", mmu.err); end
    total++; if (own_bad != 0) begin bad++; $display("FAIL to_bus_own: got %0d high cycles want 0", own_bad); end
    tick();
    total++; if (mmu.done !== 1'b0) begin bad++; $display("FAIL to_done_width: got %b want 0", mmu.done); end
    tick();
    total++; if (mmu.busy !== 1'b0) begin bad++; $display("FAIL to_busy_end: got %b want 0", mmu.busy); end
  endtask

  task automatic test_back_to_back;
    int rd_low, wr_low, dones, both_low;
    rd_low = 0; wr_low = 0; dones = 0; both_low = 0;
    uart_dataready = 1'b1;
    uart_tbre = 1'b1;
    uart_tsre = 1'b1;
    data_in = 8'h77;
    tick(); tick();
    mmu.req_read = 1'b1;
    mmu.req_write = 1'b1;
    mmu.wdata = 8'h96;
    tick();
    mmu.req_write = 1'b0;
    mmu.req_read = mmu.busy;
    total++; if ({data_oe, uart_rdn, uart_wrn} !== 3'b111 || data_out !== 8'h96)
      begin bad++; $display("FAIL b2b_e0: got oe,rdn,wrn=%b dout=%h want 111 96", {data_oe, uart_rdn, uart_wrn}, data_out); end
    for (int i = 0; i < 14; i++) begin
      tick();
      if (uart_rdn === 1'b0) rd_low++;
      if (uart_wrn === 1'b0) wr_low++;
      if (uart_rdn === 1'b0 && uart_wrn === 1'b0) both_low++;
      if (mmu.done === 1'b1) dones++;
      mmu.req_read = mmu.busy;
    end
    mmu.req_read = 1'b0;
    total++; if (rd_low != 0) begin bad++; $display("FAIL b2b_rd_strobe: got %0d low cycles want 0", rd_low); end
    total++; if (wr_low != 2) begin bad++; $display("FAIL b2b_wr_strobe: got %0d low cycles want 2", wr_low); end
    total++; if (dones != 1) begin bad++; $display("FAIL b2b_dones: got %0d want 1", dones); end
    total++; if (both_low != 0) begin bad++; $display("FAIL b2b_both_low: got %0d want 0", both_low); end
    total++; if (mmu.rdata !== 8'hA5) begin bad++; $display("FAIL b2b_rdata: got %h want a5", mmu.rdata); end
    total++; if ({mmu.busy, mmu.err} !== 2'b00)
      begin bad++; $display("FAIL b2b_end: got busy,err=%b want 00", {mmu.busy, mmu.err}); end
    uart_dataready = 1'b0;
    uart_tbre = 1'b0;
    uart_tsre = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write;
    int dones, wr_low;
    dones = 0; wr_low = 0;
    mmu.wdata = 8'hE1;
    mmu.req_write = 1'b1;
    tick();
    mmu.req_write = 1'b0;
    tick();
    total++; if (uart_wrn !== 1'b0) begin bad++; $display("FAIL rmw_wr_low: got %b want 0", uart_wrn); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({uart_wrn, data_oe, mmu.busy, bus_own, mmu.done} !== 5'b10000)
      begin bad++; $display("FAIL rmw_abort: got wrn,oe,busy,own,done=%b want 10000", {uart_wrn, data_oe, mmu.busy, bus_own, mmu.done}); end
    total++; if (mmu.rdata !== 8'h00) begin bad++; $display("FAIL rmw_rdata_clr: got %h want 00", mmu.rdata); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mmu.done === 1'b1) dones++;
      if (uart_wrn === 1'b0) wr_low++;
    end
    total++; if (dones != 0 || wr_low != 0)
      begin bad++; $display("FAIL rmw_quiet: got dones=%0d wr_low=%0d want 0 0", dones, wr_low); end
    data_in = 8'h42;
    uart_dataready = 1'b1;
    tick(); tick();
    mmu.req_read = 1'b1;
    tick();
    mmu.req_read = 1'b0;
    tick(); tick();
    total++; if ({mmu.done, mmu.rdata} !== {1'b1, 8'h42})
      begin bad++; $display("FAIL rmw_read: got done=%b rdata=%h want 1 42", mmu.done, mmu.rdata); end
    tick(); tick();
    total++; if (mmu.busy !== 1'b0) begin bad++; $display("FAIL rmw_read_busy: got %b want 0", mmu.busy); end
    uart_dataready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_no_data();
    test_read_pending();
    test_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
